// File: rtl/nitta_board_pkg.sv
// -----------------------------------------------------------------------------
// nitta_board_pkg
// Shared definitions for the NITTA DE0-Nano board logic.
//   mode_t        : run-mode encoding reported on the `state` output
//   DEF_SLOW_DIV  : default fast-clock cycles per enable in slow mode
//   DEF_DEBOUNCE  : default cycles a key level must stay stable
//   select_mode() : dip-switch priority decode (halt > step > fast > slow)
// -----------------------------------------------------------------------------
package nitta_board_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        FAST = 2'd1,
        SLOW = 2'd2,
        STEP = 2'd3
    } mode_t;

    localparam int unsigned DEF_SLOW_DIV = 32'd200_000_000;
    localparam int unsigned DEF_DEBOUNCE = 32'd1_000_000;

    // Priority decode of the synchronized dip switches.
    function automatic mode_t select_mode(input logic run,
                                          input logic boost,
                                          input logic step_mode);
        mode_t mode_v;
        if (!run) begin
            mode_v = HALT;
        end else if (step_mode) begin
            mode_v = STEP;
        end else if (boost) begin
            mode_v = FAST;
        end else begin
            mode_v = SLOW;
        end
        return mode_v;
    endfunction

endpackage

// File: rtl/nitta_clk_ctrl_if.sv
// -----------------------------------------------------------------------------
// nitta_clk_ctrl_if
// Board-side signals of the run/step controller.
//   run, boost, step_mode : asynchronous dip switches (master -> slave)
//   key_step_n            : asynchronous active-low step push-button
//   en                    : single-cycle processor clock enable (slave -> master)
//   state                 : current run mode
//   en_count              : number of enables issued, modulo 2^16
// The controller is the slave; the board / bench is the master.
// -----------------------------------------------------------------------------
interface nitta_clk_ctrl_if;
    import nitta_board_pkg::*;

    logic        run;
    logic        boost;
    logic        step_mode;
    logic        key_step_n;
    logic        en;
    mode_t       state;
    logic [15:0] en_count;

    modport master (
        output run, boost, step_mode, key_step_n,
        input  en, state, en_count
    );

    modport slave (
        input  run, boost, step_mode, key_step_n,
        output en, state, en_count
    );

endinterface

// File: rtl/nitta_clk_ctrl_debounce.sv
// -----------------------------------------------------------------------------
// nitta_debounce
// Synchronizes an asynchronous active-low key, debounces it and emits a
// one-cycle registered pulse on every accepted press (1 -> 0 transition).
//   clk, rst : fast clock, asynchronous active-high reset
//   key_n    : raw bouncing key, active low
//   press    : one-cycle pulse, registered, coincides with key_db falling
// A level must be seen on the synchronized key for DEBOUNCE consecutive
// cycles before it replaces the debounced level.
// -----------------------------------------------------------------------------
module nitta_debounce
    import nitta_board_pkg::*;
#(
    parameter int unsigned DEBOUNCE = DEF_DEBOUNCE,
    parameter int unsigned CNT_W    = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    logic             key_s1_r;
    logic             key_s2_r;
    logic             key_db_r;
    logic [CNT_W-1:0] db_cnt_r;
    logic             press_r;

    logic             key_db_next_s;
    logic [CNT_W-1:0] db_cnt_next_s;
    logic             press_next_s;

    // Two-stage synchronizer; idle (released) level is 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_s1_r <= 1'b1;
            key_s2_r <= 1'b1;
        end else begin
            key_s1_r <= key_n;
            key_s2_r <= key_s1_r;
        end
    end

    // Debounce decision: count while the synchronized key disagrees with the
    // accepted level, accept on the last count, restart on any agreement.
    always_comb begin
        key_db_next_s = key_db_r;
        db_cnt_next_s = {CNT_W{1'b0}};
        press_next_s  = 1'b0;
        if (key_s2_r != key_db_r) begin
            if (db_cnt_r == CNT_W'(DEBOUNCE - 32'd1)) begin
                key_db_next_s = key_s2_r;
                db_cnt_next_s = {CNT_W{1'b0}};
                // Key differs from key_db, so a low key here means 1 -> 0.
                press_next_s  = ~key_s2_r;
            end else begin
                key_db_next_s = key_db_r;
                db_cnt_next_s = db_cnt_r + CNT_W'(1);
                press_next_s  = 1'b0;
            end
        end else begin
            key_db_next_s = key_db_r;
            db_cnt_next_s = {CNT_W{1'b0}};
            press_next_s  = 1'b0;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_db_r <= 1'b1;
            db_cnt_r <= {CNT_W{1'b0}};
            press_r  <= 1'b0;
        end else begin
            key_db_r <= key_db_next_s;
            db_cnt_r <= db_cnt_next_s;
            press_r  <= press_next_s;
        end
    end

    assign press = press_r;

endmodule

// File: rtl/nitta_clk_ctrl.sv
// -----------------------------------------------------------------------------
// nitta_clk_ctrl
// Run/step controller for the NITTA core. Runs on the fast PLL clock and
// produces a registered single-cycle clock enable in one of four modes:
// HALT (no enables), FAST (every cycle), SLOW (one per SLOW_DIV cycles) and
// STEP (one per debounced key press). Also counts issued enables.
//   clk      : fast clock (200 MHz PLL)
//   rst      : asynchronous active-high reset
//   bus      : nitta_clk_ctrl_if.slave (dips, key, en, state, en_count)
// Latency: dip change -> state 3 edges, -> en 4 edges.
// -----------------------------------------------------------------------------
module nitta_clk_ctrl
    import nitta_board_pkg::*;
#(
    parameter int unsigned SLOW_DIV = DEF_SLOW_DIV,
    parameter int unsigned DEBOUNCE = DEF_DEBOUNCE,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    nitta_clk_ctrl_if.slave        bus
);

    logic             run_s1_r;
    logic             run_s2_r;
    logic             boost_s1_r;
    logic             boost_s2_r;
    logic             step_s1_r;
    logic             step_s2_r;

    mode_t            state_r;
    mode_t            mode_next_s;

    logic [CNT_W-1:0] slow_cnt_r;
    logic [CNT_W-1:0] slow_cnt_next_s;
    logic             en_r;
    logic             en_next_s;
    logic [15:0]      en_count_r;
    logic             press_s;

    // Key synchronizer, debouncer and press detector.
    nitta_debounce #(
        .DEBOUNCE (DEBOUNCE),
        .CNT_W    (CNT_W)
    ) u_key_step (
        .clk   (clk),
        .rst   (rst),
        .key_n (bus.key_step_n),
        .press (press_s)
    );

    // Two-stage synchronizers for the dip switches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_s1_r   <= 1'b0;
            run_s2_r   <= 1'b0;
            boost_s1_r <= 1'b0;
            boost_s2_r <= 1'b0;
            step_s1_r  <= 1'b0;
            step_s2_r  <= 1'b0;
        end else begin
            run_s1_r   <= bus.run;
            run_s2_r   <= run_s1_r;
            boost_s1_r <= bus.boost;
            boost_s2_r <= boost_s1_r;
            step_s1_r  <= bus.step_mode;
            step_s2_r  <= step_s1_r;
        end
    end

    // Mode state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= HALT;
        end else begin
            state_r <= mode_next_s;
        end
    end

    // Next mode, slow-tick counter and enable decision for the current mode.
    // Decisions use the registered mode, so a press arriving in the cycle the
    // mode leaves STEP is dropped, and the slow counter restarts on entry.
    always_comb begin
        mode_next_s     = select_mode(run_s2_r, boost_s2_r, step_s2_r);
        slow_cnt_next_s = {CNT_W{1'b0}};
        en_next_s       = 1'b0;
        case (state_r)
            HALT: begin
                slow_cnt_next_s = {CNT_W{1'b0}};
                en_next_s       = 1'b0;
            end
            FAST: begin
                slow_cnt_next_s = {CNT_W{1'b0}};
                en_next_s       = 1'b1;
            end
            SLOW: begin
                if (slow_cnt_r == CNT_W'(SLOW_DIV - 32'd1)) begin
                    slow_cnt_next_s = {CNT_W{1'b0}};
                    en_next_s       = 1'b1;
                end else begin
                    slow_cnt_next_s = slow_cnt_r + CNT_W'(1);
                    en_next_s       = 1'b0;
                end
            end
            STEP: begin
                slow_cnt_next_s = {CNT_W{1'b0}};
                en_next_s       = press_s;
            end
            default: begin
                slow_cnt_next_s = {CNT_W{1'b0}};
                en_next_s       = 1'b0;
            end
        endcase
    end

    // Enable output and slow counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slow_cnt_r <= {CNT_W{1'b0}};
            en_r       <= 1'b0;
        end else begin
            slow_cnt_r <= slow_cnt_next_s;
            en_r       <= en_next_s;
        end
    end

    // Debug count of issued enables, wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_count_r <= 16'd0;
        end else if (en_r) begin
            en_count_r <= en_count_r + 16'd1;
        end else begin
            en_count_r <= en_count_r;
        end
    end

    assign bus.en       = en_r;
    assign bus.state    = state_r;
    assign bus.en_count = en_count_r;

endmodule
